// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: sweep request/configuration inputs and DDS control outputs of the sweep sequencer
interface dds_sweep_ctrl_if #(
  parameter int M  = 24,
  parameter int CW = 16
);
  logic          start;
  logic          stop;
  logic          repeat_en;
  logic [M-1:0]  f_start;
  logic [M-1:0]  f_step;
  logic [CW-1:0] n_steps;
  logic [CW-1:0] dwell;
  logic [M-1:0]  p;
  logic          val_in;
  logic          ena_ac;
  logic          rst_ac;
  logic          busy;
  logic          done;
  logic [CW-1:0] step_idx;
  modport master (
    output start, stop, repeat_en, f_start, f_step, n_steps, dwell,
    input  p, val_in, ena_ac, rst_ac, busy, done, step_idx
  );
  modport slave (
    input  start, stop, repeat_en, f_start, f_step, n_steps, dwell,
    output p, val_in, ena_ac, rst_ac, busy, done, step_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps a DDS phase increment through a linear frequency sweep with dwell, repeat, abort and pipeline flush
module dds_sweep_ctrl #(
  parameter int M        = 24,
  parameter int CW       = 16,
  parameter int PIPE_LAT = 4
) (
  input logic          clk,
  input logic          rst_n,
  dds_sweep_ctrl_if.slave bus
);
  localparam int FW = PIPE_LAT < 2 ? 1 : $clog2(PIPE_LAT);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT < 1 ? 0 : PIPE_LAT - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SWEEP = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]    state;
  logic [M-1:0]  p, f_start_r, f_step_r;
  logic [CW-1:0] n_steps_r, dwell_r, step_idx, dwell_cnt;
  logic [CW-1:0] dwell_last, step_last;
  logic [FW-1:0] flush_cnt;
  logic          rep_r, val_in, ena_ac, rst_ac, busy, done;
  logic          dwell_end, last_step;
  // zero dwell / zero step count behave as one
  always_comb begin
    dwell_last = (dwell_r == '0) ? '0 : dwell_r - CW'(1);
    step_last  = (n_steps_r == '0) ? '0 : n_steps_r - CW'(1);
    dwell_end  = dwell_cnt == dwell_last;
    last_step  = step_idx >= step_last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      f_start_r <= '0;
      f_step_r  <= '0;
      n_steps_r <= '0;
      dwell_r   <= '0;
      rep_r     <= 1'b0;
      step_idx  <= '0;
      dwell_cnt <= '0;
      flush_cnt <= '0;
      val_in    <= 1'b0;
      ena_ac    <= 1'b0;
      rst_ac    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.stop) begin
          state     <= CLEAR;
          busy      <= 1'b1;
          rst_ac    <= 1'b1;
          f_start_r <= bus.f_start;
          f_step_r  <= bus.f_step;
          n_steps_r <= bus.n_steps;
          dwell_r   <= bus.dwell;
          rep_r     <= bus.repeat_en;
        end
        CLEAR: begin
          state     <= SWEEP;
          rst_ac    <= 1'b0;
          ena_ac    <= 1'b1;
          val_in    <= 1'b1;
          p         <= f_start_r;
          step_idx  <= '0;
          dwell_cnt <= '0;
        end
        SWEEP: begin
          // abort wins over any step advance scheduled for this cycle
          if (bus.stop) begin
            state     <= FLUSH;
            val_in    <= 1'b0;
            flush_cnt <= '0;
          end else if (dwell_end) begin
            dwell_cnt <= '0;
            if (!last_step) begin
              p        <= p + f_step_r;
              step_idx <= step_idx + CW'(1);
            end else if (rep_r) begin
              p        <= f_start_r;
              step_idx <= '0;
            end else begin
              state     <= FLUSH;
              val_in    <= 1'b0;
              flush_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            ena_ac <= 1'b0;
            p      <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          step_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.p        = p;
  assign bus.val_in   = val_in;
  assign bus.ena_ac   = ena_ac;
  assign bus.rst_ac   = rst_ac;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.step_idx = step_idx;
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameters: M, default 24, phase-increment width. CW, default 16, step and dwell counter width. PIPE_LAT, default 4, DDS val_in-to-val_out latency to flush.
REQ-002 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle sweep request; acted on only in IDLE.
REQ-005 stop  in  1  abort request; acted on only in SWEEP.
REQ-006 repeat  in  1  1 = restart the sweep after the last step; 0 = single sweep.
REQ-007 f_start  in  M  first phase increment.
REQ-008 f_step  in  M  increment added per step; unsigned, wraps modulo 2^M.
REQ-009 n_steps  in  CW  number of steps per sweep; 0 is treated as 1.
REQ-010 dwell  in  CW  cycles per step; 0 is treated as 1.
REQ-011 P  out  M  phase increment to the DDS.
REQ-012 val_in, ena_ac, rst_ac  out  1 each  DDS control: valid, accumulator enable, synchronous accumulator clear.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at the end of a sweep or abort.
REQ-015 step_idx  out  CW  current step index, starting at 0.

Function
REQ-016 FSM states: IDLE, CLEAR, SWEEP, FLUSH, DONE. All outputs are registered.
REQ-017 IDLE: P=0, val_in=0, ena_ac=0, rst_ac=0, step_idx=0, busy=0. On start=1 and stop=0 -> CLEAR; otherwise stay.
REQ-018 On the IDLE->CLEAR edge, capture f_start, f_step, n_steps, dwell and repeat. Input changes after capture are ignored until the next start.
REQ-019 CLEAR lasts exactly 1 cycle: rst_ac=1, ena_ac=0, val_in=0. Next state is SWEEP.
REQ-020 SWEEP: ena_ac=1, val_in=1, rst_ac=0. P=f_start on the first SWEEP cycle.
REQ-021 Dwell counter: P holds for exactly max(dwell,1) cycles per step.
REQ-022 On dwell expiry with step_idx < max(n_steps,1)-1: P <= P+f_step (truncated to M bits) and step_idx++, both effective on the next cycle.
REQ-023 On dwell expiry of the last step: if the captured repeat=1, P <= f_start and step_idx <= 0 with no gap cycle; otherwise -> FLUSH.
REQ-024 stop=1 in SWEEP -> FLUSH on the next cycle; this has priority over step advance. start is ignored while busy=1.
REQ-025 FLUSH: val_in=0, ena_ac=1, P held, for exactly PIPE_LAT cycles, then -> DONE.
REQ-026 DONE lasts 1 cycle: done=1, ena_ac=0, P=0, busy=1. Next state is IDLE.
REQ-027 Full sequence latency: start edge to first val_in=1 is 2 cycles (CLEAR, then SWEEP).

Reset
REQ-028 With rst_n=0, all outputs and state go to IDLE values immediately, in any state including mid-sweep. Captured configuration is cleared to 0.
REQ-029 After rst_n deasserts, the first start is accepted on the first rising edge after deassertion.

Verification
REQ-030 f_start=0x001000, f_step=0x000100, n_steps=3, dwell=2, repeat=0 -> P sequence 0x001000 x2, 0x001100 x2, 0x001200 x2; then 4 FLUSH cycles; then a 1-cycle done; total busy = 1+6+4+1 = 12 cycles.
REQ-031 dwell=0, n_steps=0 -> exactly one SWEEP cycle with P=f_start, then FLUSH.
REQ-032 f_start=0xFFFF00, f_step=0x000200, n_steps=2, dwell=1 -> second P=0x000100 (wrap).
REQ-033 repeat=1, n_steps=2, dwell=1 -> P alternates f_start, f_start+f_step every cycle with no gap; stop asserted -> FLUSH next cycle; step_idx frozen.
REQ-034 rst_n pulsed low mid-SWEEP -> P=0, val_in=ena_ac=busy=0 in the same cycle, with no done pulse.
REQ-035 start during SWEEP, and start+stop together in IDLE -> both ignored; state unchanged.
